mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the
//  MEM stage (load/store) of the pipelined CPU. Fixed data-over-fetch priority with an anti-starvation

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and load/store, data first, with a forced fetch grant
//               after STARVE_LIMIT consecutive data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                discard_q, discard_d;

    logic w_if_pend;
    logic w_d_pend;
    logic w_starved;

    // A requester whose ready pulses this cycle is finishing, not asking again.
    assign w_if_pend = if_req & ~if_ready_q & ~if_flush;
    assign w_d_pend  = d_req & ~d_ready_q;
    assign w_starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    assign stall     = (if_req & ~if_ready_q & ~if_flush) | (d_req & ~d_ready_q);
    assign mem_valid = (state_q != IDLE);
    assign mem_we    = cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;

    always_comb begin
        state_d      = state_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        if_ready_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_ready_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;
        discard_d    = discard_q;

        case (state_q)
            IDLE: begin
                if (w_if_pend && (!w_d_pend || w_starved)) begin
                    state_d      = IF_BUSY;
                    cmd_we_d     = 1'b0;
                    cmd_addr_d   = if_addr;
                    cmd_wdata_d  = '0;
                    starve_cnt_d = '0;
                end else if (w_d_pend) begin
                    state_d     = D_BUSY;
                    cmd_we_d    = d_we;
                    cmd_addr_d  = d_addr;
                    cmd_wdata_d = d_wdata;
                    if (w_if_pend && !w_starved) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            IF_BUSY: begin
                if (if_flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !if_flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            D_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    d_ready_d = 1'b1;
                    if (!cmd_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            if_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            starve_cnt_q <= '0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            if_ready_q   <= if_ready_d;
            if_rdata_q   <= if_rdata_d;
            d_ready_q    <= d_ready_d;
            d_rdata_q    <= d_rdata_d;
            starve_cnt_q <= starve_cnt_d;
            discard_q    <= discard_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, if_flush, d_req, d_we, mem_ready;
    logic [ADDR_W-1:0] if_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, mem_rdata;
    logic              if_ready, d_ready, mem_valid, mem_we, stall;
    logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_assert = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_outputs", {if_ready, d_ready, mem_we, stall}, 0);
        chk("rst_data", {if_rdata, d_rdata}, 0);
        chk("rst_cmd", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;

        // 1: load, memory answers 3 cycles after mem_valid rises
        d_req = 1; d_we = 0; d_addr = 32'h40; #1;
        chk("t1_stall_req", stall, 1);
        chk("t1_valid_c0", mem_valid, 0);
        tick();
        chk("t1_valid_c1", mem_valid, 1);
        chk("t1_cmd", {mem_we, mem_addr}, {1'b0, 32'h40});
        tick();
        chk("t1_stall_wait", stall, 1);
        tick();
        tick();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 0;
        chk("t1_d_ready", d_ready, 1);
        chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("t1_idle_stall", {mem_valid, stall}, 0);
        d_req = 0;
        tick();
        chk("t1_ready_pulse", d_ready, 0);

        // 2: simultaneous fetch and store, store wins first
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678;
        tick();
        chk("t2_d_first", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b1, 32'h80});
        chk("t2_wdata", mem_wdata, 32'h12345678);
        tick();
        mem_ready = 1; mem_rdata = 32'hCAFE0001;
        tick();
        mem_ready = 0;
        chk("t2_store_done", {d_ready, mem_valid, stall}, {1'b1, 1'b0, 1'b1});
        chk("t2_d_rdata_kept", d_rdata, 32'hDEADBEEF);
        d_req = 0; d_we = 0;
        tick();
        chk("t2_if_grant", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100});
        chk("t2_d_ready_low", d_ready, 0);
        tick();
        mem_ready = 1; mem_rdata = 32'h00A00093;
        tick();
        mem_ready = 0;
        chk("t2_if_ready", if_ready, 1);
        chk("t2_if_rdata", if_rdata, 32'h00A00093);
        if_req = 0;
        tick();
        chk("t2_if_pulse", if_ready, 0);

        // 3: starvation. A data completion leaves IDLE with d_ready high, so a
        // redirect is placed in each such cycle to keep the fetch from winning it.
        if_req = 1; if_addr = 32'h180; d_req = 1; d_we = 0; d_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_d_grant%0d", i), {mem_valid, mem_we, mem_addr},
                {1'b1, 1'b0, 32'h400 + 32'(4 * i)});
            mem_ready = 1; mem_rdata = 32'(i + 1);
            tick();
            mem_ready = 0;
            chk($sformatf("t3_d_done%0d", i), {d_ready, d_rdata}, {1'b1, 32'(i + 1)});
            if_flush = 1; d_addr = 32'h400 + 32'(4 * (i + 1));
            tick();
            if_flush = 0;
            chk($sformatf("t3_gap_idle%0d", i), mem_valid, 0);
        end
        tick();
        chk("t3_if_forced", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, 32'h180});
        chk("t3_starve_clr", dut.starve_cnt_q, 0);
        mem_ready = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ready = 0;
        chk("t3_if_data", {if_ready, if_rdata}, {1'b1, 32'h11111111});
        if_req = 0;
        tick();
        chk("t3_d5_grant", {mem_valid, mem_addr}, {1'b1, 32'h410});
        mem_ready = 1; mem_rdata = 32'h5;
        tick();
        mem_ready = 0;
        chk("t3_d5_done", {d_ready, d_rdata}, {1'b1, 32'h5});
        d_req = 0;
        tick();

        // 4: flush while fetch in flight, then redirected fetch
        if_req = 1; if_addr = 32'h200;
        tick();
        chk("t4_if_grant", {mem_valid, mem_addr}, {1'b1, 32'h200});
        if_flush = 1;
        tick();
        if_flush = 0; if_addr = 32'h300;
        mem_ready = 1; mem_rdata = 32'h00000013;
        tick();
        mem_ready = 0;
        chk("t4_no_ready", {if_ready, mem_valid}, 0);
        chk("t4_rdata_kept", if_rdata, 32'h11111111);
        tick();
        chk("t4_new_grant", {mem_valid, mem_addr}, {1'b1, 32'h300});
        mem_ready = 1; mem_rdata = 32'h00000517;
        tick();
        mem_ready = 0;
        chk("t4_new_data", {if_ready, if_rdata}, {1'b1, 32'h00000517});
        if_req = 0;
        tick();

        // 5: reset in the middle of a load
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick();
        chk("t5_busy", mem_valid, 1);
        tick();
        reset = 1; d_req = 0; #1;
        chk("t5_rst_now", {mem_valid, d_ready, if_ready}, 0);
        chk("t5_rst_data", {d_rdata, if_rdata, mem_addr}, 0);
        tick();
        reset = 0;
        tick();
        mem_ready = 1; mem_rdata = 32'h00000BAD;
        tick();
        mem_ready = 0;
        chk("t5_late_ready", {d_ready, if_ready, mem_valid}, 0);
        chk("t5_late_data", d_rdata, 0);

        // 6: stray mem_ready while idle
        mem_ready = 1; mem_rdata = 32'h55;
        tick();
        mem_ready = 0;
        chk("t6_idle_ready", {d_ready, if_ready, mem_valid, stall}, 0);
        chk("t6_idle_data", {d_rdata, if_rdata}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
